// File: rtl/cpu4_wbu_pkg.sv
// Shared widths and types for the CPU4 write-back unit.
package cpu4_wbu_pkg;

  localparam int unsigned CPU4_XLEN        = 32;
  localparam int unsigned CPU4_RFIDX_WIDTH = 5;
  localparam int unsigned CPU4_RFREG_NUM   = 32;

  // One pending register-file write: destination index plus value.
  typedef struct packed {
    logic [CPU4_RFIDX_WIDTH-1:0] idx;
    logic [CPU4_XLEN-1:0]        data;
  } wb_entry_t;

  // Which source feeds the write-back output register this cycle.
  typedef enum logic [1:0] {
    SrcNone,
    SrcLsu,
    SrcAlu
  } wb_src_e;

  // One-hot decode of a register index into a scoreboard-wide mask.
  function automatic logic [CPU4_RFREG_NUM-1:0] idx_dec(input logic [CPU4_RFIDX_WIDTH-1:0] idx);
    logic [CPU4_RFREG_NUM-1:0] dec;
    dec      = '0;
    dec[idx] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/cpu4_wb_fifo.sv
// Two-entry ALU result buffer: push when not full, pop strobe, head always visible.
module cpu4_wb_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'(Depth));
  assign push_en = push_valid & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + 2'(push_en) - 2'(pop_en);
    if (push_en) wr_ptr_d = ~wr_ptr_q;
    if (pop_en)  rd_ptr_d = ~rd_ptr_q;
  end

  // Control state register; reset empties the buffer, discarding contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; stale data is harmless because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cpu4_wbu.sv
// Write-back unit: arbitrates load responses and buffered ALU results onto the
// register-file write port, and tracks outstanding loads in a scoreboard.
module cpu4_wbu
  import cpu4_wbu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_wb_valid,
  output logic                        alu_wb_ready,
  input  logic [CPU4_RFIDX_WIDTH-1:0] alu_wb_idx,
  input  logic [CPU4_XLEN-1:0]        alu_wb_data,
  input  logic                        lsu_req_valid,
  input  logic [CPU4_RFIDX_WIDTH-1:0] lsu_req_idx,
  input  logic                        lsu_rsp_valid,
  input  logic [CPU4_RFIDX_WIDTH-1:0] lsu_rsp_idx,
  input  logic [CPU4_XLEN-1:0]        lsu_rsp_data,
  output logic                        rd_wen,
  output logic [CPU4_RFIDX_WIDTH-1:0] rd_idx,
  output logic [CPU4_XLEN-1:0]        rd_data,
  output logic [CPU4_RFREG_NUM-1:0]   busy,
  output logic                        wb_err
);

  localparam int unsigned WB_FIFO_DEPTH = 2;

  wb_entry_t                     push_entry;
  wb_entry_t                     head_entry;
  logic                          fifo_empty;
  logic                          fifo_full;
  logic                          fifo_pop;
  logic                          alu_push_valid;
  logic                          alu_hs;
  wb_src_e                       src;

  logic                          rd_wen_q, rd_wen_d;
  logic [CPU4_RFIDX_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic [CPU4_XLEN-1:0]          rd_data_q, rd_data_d;
  logic [CPU4_RFREG_NUM-1:0]     busy_q, busy_d;
  logic [CPU4_RFREG_NUM-1:0]     busy_set, busy_clr;
  logic                          err_q, err_d;
  logic                          req_err, rsp_err, alu_err;

  // Ready depends only on registered occupancy, never on same-cycle inputs.
  assign alu_wb_ready   = ~fifo_full;
  assign alu_push_valid = alu_wb_valid & ~rst;
  assign alu_hs         = alu_push_valid & alu_wb_ready;
  assign push_entry     = '{idx: alu_wb_idx, data: alu_wb_data};

  cpu4_wb_fifo #(
    .Width ($bits(wb_entry_t)),
    .Depth (WB_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (alu_push_valid),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .head       (head_entry),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Source select: load responses cannot be stalled, so they take priority.
  always_comb begin
    src = SrcNone;
    if (rst)                src = SrcNone;
    else if (lsu_rsp_valid) src = SrcLsu;
    else if (!fifo_empty)   src = SrcAlu;
  end

  assign fifo_pop = (src == SrcAlu);

  // Output register next-state; index 0 is retired without a write.
  always_comb begin
    rd_wen_d  = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_data_d = rd_data_q;
    unique case (src)
      SrcLsu: begin
        rd_wen_d  = (lsu_rsp_idx != '0);
        rd_idx_d  = lsu_rsp_idx;
        rd_data_d = lsu_rsp_data;
      end
      SrcAlu: begin
        rd_wen_d  = (head_entry.idx != '0);
        rd_idx_d  = head_entry.idx;
        rd_data_d = head_entry.data;
      end
      default: ;
    endcase
  end

  // Scoreboard next-state; a same-cycle set overrides a clear of the same bit.
  always_comb begin
    busy_set  = lsu_req_valid ? idx_dec(lsu_req_idx) : '0;
    busy_clr  = lsu_rsp_valid ? idx_dec(lsu_rsp_idx) : '0;
    busy_d    = (busy_q & ~busy_clr) | busy_set;
    busy_d[0] = 1'b0;
  end

  // Protocol checks observe the pre-update scoreboard and never affect data flow.
  always_comb begin
    req_err = lsu_req_valid && (lsu_req_idx != '0) && busy_q[lsu_req_idx] &&
              !(lsu_rsp_valid && (lsu_rsp_idx == lsu_req_idx));
    rsp_err = lsu_rsp_valid && (lsu_rsp_idx != '0) && !busy_q[lsu_rsp_idx];
    alu_err = alu_hs && (alu_wb_idx != '0) && busy_q[alu_wb_idx];
    err_d   = err_q | req_err | rsp_err | alu_err;
  end

  // State registers; reset clears everything and ignores all input valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_wen_q  <= rd_wen_d;
      rd_idx_q  <= rd_idx_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign rd_wen  = rd_wen_q;
  assign rd_idx  = rd_idx_q;
  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign wb_err  = err_q;

endmodule

// File: tb/tb_cpu4_wbu.sv
// Directed bench for cpu4_wbu with a write-prediction scoreboard.
module tb_cpu4_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_valid;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_idx;
  logic [31:0] alu_wb_data;
  logic        lsu_req_valid;
  logic [4:0]  lsu_req_idx;
  logic        lsu_rsp_valid;
  logic [4:0]  lsu_rsp_idx;
  logic [31:0] lsu_rsp_data;
  logic        rd_wen;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic [31:0] busy;
  logic        wb_err;

  always #5 clk = ~clk;

  cpu4_wbu dut (
    .clk           (clk),
    .rst           (rst),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_ready  (alu_wb_ready),
    .alu_wb_idx    (alu_wb_idx),
    .alu_wb_data   (alu_wb_data),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_idx   (lsu_req_idx),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_idx   (lsu_rsp_idx),
    .lsu_rsp_data  (lsu_rsp_data),
    .rd_wen        (rd_wen),
    .rd_idx        (rd_idx),
    .rd_data       (rd_data),
    .busy          (busy),
    .wb_err        (wb_err)
  );

  typedef struct packed {
    logic        wen;
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];   // predicted output-register contents, one per edge
  wr_t         mfifo[$];   // model of accepted-but-unwritten ALU results
  logic [31:0] mbusy;
  logic        merr;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic        last_acc;
  int          checks = 0;
  int          errors = 0;
  int          k;
  logic [4:0]  ids [3] = '{5'd1, 5'd2, 5'd3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Predict this edge's effect from the driven inputs, clock it, then compare.
  task automatic tick();
    wr_t         w;
    wr_t         e;
    logic        rdy;
    logic [31:0] nb;
    last_acc = 1'b0;
    w = '{wen: 1'b0, idx: 5'd0, data: 32'd0};
    if (rst) begin
      mfifo.delete();
      mbusy  = '0;
      merr   = 1'b0;
      m_idx  = '0;
      m_data = '0;
    end else begin
      rdy = (mfifo.size() < 2);
      chk("alu_wb_ready", {31'd0, alu_wb_ready}, {31'd0, rdy});
      w.idx  = m_idx;
      w.data = m_data;
      if (lsu_rsp_valid) begin
        w = '{wen: (lsu_rsp_idx != 0), idx: lsu_rsp_idx, data: lsu_rsp_data};
      end else if (mfifo.size() > 0) begin
        e = mfifo.pop_front();
        w = '{wen: (e.idx != 0), idx: e.idx, data: e.data};
      end
      m_idx  = w.idx;
      m_data = w.data;
      if (lsu_req_valid && lsu_req_idx != 0 && mbusy[lsu_req_idx] &&
          !(lsu_rsp_valid && lsu_rsp_idx == lsu_req_idx)) merr = 1'b1;
      if (lsu_rsp_valid && lsu_rsp_idx != 0 && !mbusy[lsu_rsp_idx]) merr = 1'b1;
      if (alu_wb_valid && rdy && alu_wb_idx != 0 && mbusy[alu_wb_idx]) merr = 1'b1;
      if (alu_wb_valid && rdy) begin
        mfifo.push_back('{wen: 1'b1, idx: alu_wb_idx, data: alu_wb_data});
        last_acc = 1'b1;
      end
      nb = mbusy;
      if (lsu_rsp_valid) nb[lsu_rsp_idx] = 1'b0;
      if (lsu_req_valid && lsu_req_idx != 0) nb[lsu_req_idx] = 1'b1;
      mbusy = nb;
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    chk("rd_wen", {31'd0, rd_wen}, {31'd0, w.wen});
    chk("rd_idx", {27'd0, rd_idx}, {27'd0, w.idx});
    chk("rd_data", rd_data, w.data);
    chk("busy", busy, mbusy);
    chk("wb_err", {31'd0, wb_err}, {31'd0, merr});
  endtask

  initial begin
    rst = 1'b1;
    alu_wb_valid = 1'b1; alu_wb_idx = 5'd3; alu_wb_data = 32'hDEAD;
    lsu_req_valid = 1'b1; lsu_req_idx = 5'd6;
    lsu_rsp_valid = 1'b0; lsu_rsp_idx = 5'd0; lsu_rsp_data = 32'd0;
    tick();
    tick();
    alu_wb_valid = 1'b0; lsu_req_valid = 1'b0;
    rst = 1'b0;

    // Single ALU write: visible two edges after the handshake only.
    alu_wb_valid = 1'b1; alu_wb_idx = 5'd5; alu_wb_data = 32'h1234;
    tick();
    alu_wb_valid = 1'b0;
    repeat (3) tick();

    // Back-to-back ALU stream: simultaneous push and pop, order kept.
    for (int i = 0; i < 4; i++) begin
      alu_wb_valid = 1'b1; alu_wb_idx = 5'(10 + i); alu_wb_data = 32'hA0 + 32'(i);
      tick();
      chk("stream_accept", {31'd0, last_acc}, 32'd1);
    end
    alu_wb_valid = 1'b0;
    repeat (3) tick();

    // Scoreboard set, clear with write, and set-wins on collision.
    lsu_req_valid = 1'b1; lsu_req_idx = 5'd9;
    tick();
    lsu_req_valid = 1'b0;
    lsu_rsp_valid = 1'b1; lsu_rsp_idx = 5'd9; lsu_rsp_data = 32'hCAFE;
    tick();
    lsu_rsp_valid = 1'b0;
    lsu_req_valid = 1'b1;
    tick();
    lsu_rsp_valid = 1'b1; lsu_rsp_data = 32'hBEEF;
    tick();
    lsu_req_valid = 1'b0; lsu_rsp_data = 32'h1;
    tick();
    lsu_rsp_valid = 1'b0;
    tick();

    // Index 0: consumed silently, no scoreboard bit, no error.
    alu_wb_valid = 1'b1; alu_wb_idx = 5'd0; alu_wb_data = 32'hFFFF;
    lsu_req_valid = 1'b1; lsu_req_idx = 5'd0;
    tick();
    alu_wb_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (3) tick();
    chk("err_clean", {31'd0, wb_err}, 32'd0);

    // ALU result to a register with a load outstanding.
    lsu_req_valid = 1'b1; lsu_req_idx = 5'd12;
    tick();
    lsu_req_valid = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_idx = 5'd12; alu_wb_data = 32'h55;
    tick();
    alu_wb_valid = 1'b0;
    repeat (2) tick();
    lsu_rsp_valid = 1'b1; lsu_rsp_idx = 5'd12; lsu_rsp_data = 32'h66;
    tick();
    lsu_rsp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Load responses outrank three queued ALU results; ready drops when full.
    lsu_req_valid = 1'b1; lsu_req_idx = 5'd7;
    tick();
    lsu_req_valid = 1'b0;
    k = 0;
    alu_wb_valid = 1'b1;
    for (int c = 0; c < 12 && k < 3; c++) begin
      alu_wb_idx = ids[k]; alu_wb_data = 32'h100 + 32'(k);
      lsu_rsp_valid = (c < 3); lsu_rsp_idx = 5'd7; lsu_rsp_data = 32'h77;
      tick();
      if (last_acc) k++;
    end
    alu_wb_valid = 1'b0; lsu_rsp_valid = 1'b0;
    repeat (4) tick();
    chk("alu_burst_accepted", 32'(k), 32'd3);

    // Sticky error on a stray response, then reset with a full buffer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lsu_rsp_valid = 1'b1; lsu_rsp_idx = 5'd4; lsu_rsp_data = 32'h44;
    tick();
    lsu_rsp_valid = 1'b0;
    repeat (3) tick();
    k = 0;
    lsu_rsp_valid = 1'b1;
    alu_wb_valid = 1'b1;
    for (int c = 0; c < 6 && k < 2; c++) begin
      alu_wb_idx = 5'(20 + k); alu_wb_data = 32'h200 + 32'(k);
      tick();
      if (last_acc) k++;
    end
    chk("fill_accepted", 32'(k), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0; alu_wb_valid = 1'b0; lsu_rsp_valid = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
